hazard_ctrl: RTL and testbench

Hazard and sequencing controller for the 5-stage pipeline. It generates every stall, flush and forward control for the Fetch→Decode, Decode→Execute, Execute→Memory and Memory→Writeback pipe registers. It resolves load-use hazards, PC-write (branch / R15 write) hazards and data-memory wait states. It also keeps saturating stall/flush cycle counters for performance debug.

---
 rtl/hazard_ctrl.sv | 126 ++++++++++++
 tb/tb_hazard_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: forwarding, stall/flush
// generation, data-memory wait/timeout FSM and saturating stall/flush counters.
module hazard_ctrl #(
  parameter int unsigned REG_AW      = 4,
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] Ra1D,
  input  logic [REG_AW-1:0] Ra2D,
  input  logic [REG_AW-1:0] Ra1E,
  input  logic [REG_AW-1:0] Ra2E,
  input  logic [REG_AW-1:0] WA3E,
  input  logic [REG_AW-1:0] WA3M,
  input  logic [REG_AW-1:0] WA3W,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              MemtoRegE,
  input  logic              PCSrcD,
  input  logic              PCSrcE,
  input  logic              PCSrcM,
  input  logic              PCSrcW,
  input  logic              BranchTakenE,
  input  logic              MemReqM,
  input  logic              MemReadyM,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushW,
  output logic              MemErr,
  output logic [CNT_W-1:0]  StallCnt,
  output logic [CNT_W-1:0]  FlushCnt
);

  localparam int unsigned WCNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {S_RUN = 2'd0, S_WAIT = 2'd1, S_ERR = 2'd2} state_t;

  state_t            state, state_n;
  logic [WCNT_W-1:0] wait_cnt, wait_cnt_n;
  logic              ldstall, pcpend, memstall;

  // State, wait counter, sticky error and saturating perf counters
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_RUN;
      wait_cnt <= '0;
      MemErr   <= 1'b0;
      StallCnt <= '0;
      FlushCnt <= '0;
    end else begin
      state    <= state_n;
      wait_cnt <= wait_cnt_n;
      if (state_n == S_ERR) MemErr <= 1'b1;
      if (StallF && (StallCnt != '1)) StallCnt <= StallCnt + CNT_W'(1);
      if (FlushD && (FlushCnt != '1)) FlushCnt <= FlushCnt + CNT_W'(1);
    end
  end

  // Memory wait FSM next-state
  always_comb begin
    state_n    = state;
    wait_cnt_n = wait_cnt;
    case (state)
      S_RUN: begin
        if (MemReqM && !MemReadyM) begin
          state_n    = S_WAIT;
          wait_cnt_n = '0;
        end
      end
      S_WAIT: begin
        if (MemReadyM || !MemReqM)  state_n = S_RUN;
        else if (wait_cnt == WCNT_LAST) state_n = S_ERR;
        else wait_cnt_n = wait_cnt + WCNT_W'(1);
      end
      S_ERR:   state_n = S_ERR;
      default: state_n = S_RUN;
    endcase
  end

  assign ldstall  = MemtoRegE && ((Ra1D == WA3E) || (Ra2D == WA3E));
  assign pcpend   = PCSrcD || PCSrcE || PCSrcM;
  assign memstall = (state == S_ERR) || (MemReqM && !MemReadyM);

  // Zero-latency forward/stall/flush controls; memory stall dominates everything else
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b1;
    FlushE    = 1'b1;
    FlushW    = 1'b1;
    if (!reset) begin
      if (RegWriteM && (Ra1E == WA3M))      ForwardAE = 2'b10;
      else if (RegWriteW && (Ra1E == WA3W)) ForwardAE = 2'b01;
      if (RegWriteM && (Ra2E == WA3M))      ForwardBE = 2'b10;
      else if (RegWriteW && (Ra2E == WA3W)) ForwardBE = 2'b01;
      if (memstall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushW = 1'b1;
      end else begin
        StallF = ldstall || pcpend;
        StallD = ldstall;
        FlushD = pcpend || PCSrcW || BranchTakenE;
        FlushE = ldstall || BranchTakenE;
        FlushW = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed test-plan sequences plus randomized
// stimulus, all checked every cycle against a rule-level reference model.
module tb_hazard_ctrl;

  localparam int unsigned AW = 4;
  localparam int unsigned MT = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] Ra1D, Ra2D, Ra1E, Ra2E, WA3E, WA3M, WA3W;
  logic          RegWriteM, RegWriteW, MemtoRegE;
  logic          PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE, MemReqM, MemReadyM;

  logic [1:0]  fa0, fb0, fa1, fb1;
  logic        sf0, sd0, se0, sm0, fd0, fe0, fw0, me0;
  logic        sf1, sd1, se1, sm1, fd1, fe1, fw1, me1;
  logic [15:0] sc0, fc0;
  logic [1:0]  sc1, fc1;

  int checks = 0;
  int errors = 0;

  // Model state: sticky error, consecutive unready-cycle run, unsaturated totals
  bit model_err;
  int unready_run;
  int stall_tot, flush_tot;

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_AW(AW), .MEM_TIMEOUT(MT), .CNT_W(16)) u0 (
    .clk(clk), .reset(reset), .Ra1D(Ra1D), .Ra2D(Ra2D), .Ra1E(Ra1E), .Ra2E(Ra2E),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM),
    .PCSrcW(PCSrcW), .BranchTakenE(BranchTakenE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .ForwardAE(fa0), .ForwardBE(fb0), .StallF(sf0), .StallD(sd0), .StallE(se0),
    .StallM(sm0), .FlushD(fd0), .FlushE(fe0), .FlushW(fw0), .MemErr(me0),
    .StallCnt(sc0), .FlushCnt(fc0));

  hazard_ctrl #(.REG_AW(AW), .MEM_TIMEOUT(MT), .CNT_W(2)) u1 (
    .clk(clk), .reset(reset), .Ra1D(Ra1D), .Ra2D(Ra2D), .Ra1E(Ra1E), .Ra2E(Ra2E),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM),
    .PCSrcW(PCSrcW), .BranchTakenE(BranchTakenE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .ForwardAE(fa1), .ForwardBE(fb1), .StallF(sf1), .StallD(sd1), .StallE(se1),
    .StallM(sm1), .FlushD(fd1), .FlushE(fe1), .FlushW(fw1), .MemErr(me1),
    .StallCnt(sc1), .FlushCnt(fc1));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic int fwd(input logic [AW-1:0] ra);
    if (RegWriteM && ra == WA3M) return 2;
    if (RegWriteW && ra == WA3W) return 1;
    return 0;
  endfunction

  function automatic int sat(input int v, input int w);
    int mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  // Expected combinational controls from the rules in effect this cycle
  bit e_sf, e_sd, e_sm, e_fd, e_fe, e_fw;
  int e_fa, e_fb;

  task automatic expect_now();
    bit ld, pc, ms;
    ld = MemtoRegE && (Ra1D == WA3E || Ra2D == WA3E);
    pc = PCSrcD || PCSrcE || PCSrcM;
    ms = model_err || (MemReqM && !MemReadyM);
    if (reset) begin
      e_fa = 0; e_fb = 0;
      {e_sf, e_sd, e_sm} = 3'b000;
      {e_fd, e_fe, e_fw} = 3'b111;
    end else begin
      e_fa = fwd(Ra1E); e_fb = fwd(Ra2E);
      e_sf = ms || ld || pc;
      e_sd = ms || ld;
      e_sm = ms;
      e_fd = !ms && (pc || PCSrcW || BranchTakenE);
      e_fe = !ms && (ld || BranchTakenE);
      e_fw = ms;
    end
  endtask

  task automatic sample();
    @(negedge clk);
    expect_now();
    chk("ForwardAE", int'(fa0), e_fa);
    chk("ForwardBE", int'(fb0), e_fb);
    chk("StallF", int'(sf0), int'(e_sf));
    chk("StallD", int'(sd0), int'(e_sd));
    chk("StallE", int'(se0), int'(e_sm));
    chk("StallM", int'(sm0), int'(e_sm));
    chk("FlushD", int'(fd0), int'(e_fd));
    chk("FlushE", int'(fe0), int'(e_fe));
    chk("FlushW", int'(fw0), int'(e_fw));
    chk("MemErr", int'(me0), int'(model_err));
    chk("StallCnt", int'(sc0), sat(stall_tot, 16));
    chk("FlushCnt", int'(fc0), sat(flush_tot, 16));
    chk("StallCnt_w2", int'(sc1), sat(stall_tot, 2));
    chk("FlushCnt_w2", int'(fc1), sat(flush_tot, 2));
    chk("MemErr_w2", int'(me1), int'(model_err));
    chk("StallF_w2", int'(sf1), int'(e_sf));
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) begin
      model_err = 0; unready_run = 0; stall_tot = 0; flush_tot = 0;
    end else begin
      if (e_sf) stall_tot++;
      if (e_fd) flush_tot++;
      if (!model_err) begin
        if (MemReqM && !MemReadyM) unready_run++;
        else unready_run = 0;
        if (unready_run == MT + 1) model_err = 1;
      end
    end
    #1;
  endtask

  task automatic idle();
    {Ra1D, Ra2D, Ra1E, Ra2E} = '0;
    WA3E = 4'd9; WA3M = 4'd10; WA3W = 4'd11;
    {RegWriteM, RegWriteW, MemtoRegE} = '0;
    {PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE, MemReqM, MemReadyM} = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sample();
    chk("rst_FlushW", int'(fw0), 1);
    chk("rst_StallF", int'(sf0), 0);
    tick();
    reset = 1'b0;
  endtask

  initial begin
    model_err = 0; unready_run = 0; stall_tot = 0; flush_tot = 0;
    idle();
    reset = 1'b1;
    #1;
    do_reset();
    sample();
    chk("post_rst_StallCnt", int'(sc0), 0);
    chk("post_rst_MemErr", int'(me0), 0);
    tick();

    // Forwarding priority
    Ra1E = 4'd3; WA3M = 4'd3; WA3W = 4'd3; RegWriteM = 1; RegWriteW = 1;
    sample(); chk("fwd_M", int'(fa0), 2); tick();
    RegWriteM = 0;
    sample(); chk("fwd_W", int'(fa0), 1); tick();
    RegWriteW = 0;
    sample(); chk("fwd_none", int'(fa0), 0); tick();

    // Load-use
    idle(); do_reset();
    MemtoRegE = 1; WA3E = 4'd5; Ra2D = 4'd5;
    sample();
    chk("lu_StallF", int'(sf0), 1); chk("lu_StallD", int'(sd0), 1);
    chk("lu_FlushE", int'(fe0), 1); chk("lu_FlushD", int'(fd0), 0);
    tick();
    idle();
    sample(); chk("lu_StallCnt", int'(sc0), 1); tick();

    // PC write through D, E, M, W
    do_reset();
    for (int i = 0; i < 4; i++) begin
      {PCSrcD, PCSrcE, PCSrcM, PCSrcW} = 4'b1000 >> i;
      sample(); chk("pc_FlushD", int'(fd0), 1); chk("pc_StallF", int'(sf0), (i < 3) ? 1 : 0);
      tick();
    end
    idle();
    sample(); chk("pc_FlushCnt", int'(fc0), 4); chk("pc_StallCnt", int'(sc0), 3); tick();

    // Memory wait with a taken branch held off
    do_reset();
    MemReqM = 1; MemReadyM = 0; BranchTakenE = 1;
    for (int i = 0; i < 3; i++) begin
      sample();
      chk("mw_StallM", int'(sm0), 1); chk("mw_FlushW", int'(fw0), 1);
      chk("mw_FlushD", int'(fd0), 0); chk("mw_FlushE", int'(fe0), 0);
      tick();
    end
    MemReadyM = 1; BranchTakenE = 0;
    sample(); chk("mw_resume_StallM", int'(sm0), 0); tick();
    idle();
    sample(); chk("mw_MemErr", int'(me0), 0); tick();

    // Timeout into ERR, then recovery by reset
    do_reset();
    MemReqM = 1; MemReadyM = 0;
    for (int c = 0; c < 9; c++) begin
      sample(); chk("to_MemErr", int'(me0), (c >= 5) ? 1 : 0); chk("to_StallD", int'(sd0), 1);
      tick();
    end
    MemReqM = 0;
    sample(); chk("err_sticky_StallF", int'(sf0), 1); tick();
    do_reset();
    sample(); chk("rec_MemErr", int'(me0), 0); chk("rec_StallF", int'(sf0), 0); tick();

    // Counter saturation on the 2-bit instance
    do_reset();
    PCSrcD = 1;
    for (int i = 0; i < 6; i++) begin sample(); tick(); end
    idle();
    sample(); chk("sat_w2", int'(sc1), 3); chk("sat_w16", int'(sc0), 6); tick();

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      reset = ($urandom_range(0, 199) == 0);
      Ra1D = 4'($urandom_range(0, 3)); Ra2D = 4'($urandom_range(0, 3));
      Ra1E = 4'($urandom_range(0, 3)); Ra2E = 4'($urandom_range(0, 3));
      WA3E = 4'($urandom_range(0, 3)); WA3M = 4'($urandom_range(0, 3));
      WA3W = 4'($urandom_range(0, 3));
      RegWriteM = 1'($urandom); RegWriteW = 1'($urandom);
      MemtoRegE = ($urandom_range(0, 3) == 0);
      PCSrcD = ($urandom_range(0, 7) == 0); PCSrcE = ($urandom_range(0, 7) == 0);
      PCSrcM = ($urandom_range(0, 7) == 0); PCSrcW = ($urandom_range(0, 7) == 0);
      BranchTakenE = ($urandom_range(0, 7) == 0);
      MemReqM = ($urandom_range(0, 9) < 6);
      MemReadyM = ($urandom_range(0, 9) < 5);
      sample(); tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
